hidden_layer_sequencer: RTL and testbench
=========================================

// Module: hidden_layer_sequencer
// PURPOSE
//  Sequences the hidden-layer pass of the network: walks the hidden weight ROM and input-vector RAM
//  (both sync-read, 1-cycle latency), emits MAC control strobes aligned to returned data, and hands
//  each finished neuron downstream via valid/ready. Sits between top-level control and the hidden MAC/activation datapath.
// PARAMETERS
//  NUM_INPUTS   784  inputs per neuron (input RAM depth)
//  NUM_HIDDEN   32   hidden neurons
//  ADDR_WIDTH   15   weight ROM address width
//  IN_ADDR_W    10   input RAM address width; 2**IN_ADDR_W >= NUM_INPUTS
// PORTS
//  clk           in   1           system clock, all logic posedge
//  rst           in   1           synchronous, active-high reset
//  start         in   1           1-cycle request to run one full hidden pass
//  busy          out  1           high from accepted start until done
//  done          out  1           1-cycle pulse after last neuron accepted
//  weight_addr   out  ADDR_WIDTH  hidden weight ROM address
//  input_addr    out  IN_ADDR_W   input RAM address
//  mac_clr       out  1           with first mac_en of a neuron: load product instead of accumulate
//  mac_en        out  1           ROM/RAM data valid this cycle; MAC must consume it
//  neuron_valid  out  1           accumulator of neuron_idx complete
//  neuron_ready  in   1           downstream accepted neuron (valid&ready)
//  neuron_idx    out  5           index of current neuron (clog2(NUM_HIDDEN))
// BEHAVIOUR
//  Reset: state IDLE; busy, done, mac_clr, mac_en, neuron_valid = 0; weight_addr, input_addr, neuron_idx = 0.
//  FSM states IDLE, FETCH, DRAIN, EMIT, FIN:
//   IDLE : start=1 -> FETCH, busy=1, neuron_idx=0, base=0. start while busy is ignored (no queueing).
//   FETCH: each cycle issue input_addr=i, weight_addr=base+i, i=0..NUM_INPUTS-1; after i=NUM_INPUTS-1 -> DRAIN.
//   DRAIN: 1 cycle, covers read latency of last issued address -> EMIT.
//   EMIT : neuron_valid=1 held (idx stable) until neuron_ready; on handshake: last neuron -> FIN,
//          else neuron_idx+1, base+=NUM_INPUTS, i=0 -> FETCH. ready=1 on first EMIT cycle = 1 cycle EMIT.
//   FIN  : done=1 one cycle, busy=0 next cycle -> IDLE.
//  mac_en = FETCH-issue registered 1 cycle (aligned to weight_q/input_q); mac_clr = mac_en for i==0 only.
//  Addresses by running adders (base, i), no multiplier; weight_addr = neuron_idx*NUM_INPUTS+i exactly.
//  Per neuron (ready always high): NUM_INPUTS FETCH + 1 DRAIN + 1 EMIT cycles; neuron_valid asserts cycle after last mac_en.
//  Addresses hold last value outside FETCH; no wrap: elaboration check NUM_HIDDEN*NUM_INPUTS(+NUM_HIDDEN w/ bias) <= 2**ADDR_WIDTH.
//  rst mid-pass: immediate return to reset values next cycle; partial neuron discarded, no done pulse.
//  start coincident with rst: rst wins.
// CONFIGURATION
//  HIDDEN_SEQ_BIAS_EN defined: FETCH issues one extra address per neuron,
//   weight_addr = NUM_HIDDEN*NUM_INPUTS + neuron_idx, input_addr held; aligned cycle drives extra
//   output bias_en (1 bit, reset 0) instead of mac_en; per-neuron cycle count +1.
//  Undefined: no bias_en port, no bias fetch, timing as above.
// STRUCTURE
//  Package nn_pkg: state enum hseq_state_t, DATA_WIDTH=8, default NUM_INPUTS/NUM_HIDDEN/ADDR_WIDTH,
//   bias-region base constant. FSM + counters in this module; one sub-module hseq_addr_gen
//   (base/i counters, weight_addr/input_addr, last-input flag) is natural.
// TESTING (bench uses NUM_INPUTS=4, NUM_HIDDEN=3 plus one default-param run)
//  1 Reset: hold rst 3 cycles -> all outputs 0, state IDLE; release, no start -> outputs stay 0.
//  2 Pass, ready tied 1: start -> weight_addr 0..11 in 3 bursts of 4, input_addr 0..3 per burst,
//    mac_en 4 per burst with mac_clr on 1st, neuron_valid idx 0,1,2, done 19 cycles after start.
//  3 Backpressure: ready low 5 cycles at idx 1 -> neuron_valid/idx held, no addr change, done 5 cycles late.
//  4 start pulsed during FETCH of neuron 1 -> ignored, single done, addresses unchanged.
//  5 rst asserted at weight_addr=6 -> next cycle all outputs 0; new start restarts at addr 0.
//  6 HIDDEN_SEQ_BIAS_EN: bias addrs 12,13,14 after each burst, bias_en aligned, done 22 cycles after start;
//    default params: 25088 mac_en total, last weight_addr 25087.

Source files
------------

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
//   Shared types and constants for the network sequencing logic.
//   - hseq_state_t : hidden-layer sequencer FSM states
//   - DATA_WIDTH   : datapath word width of weights / inputs
//   - DEF_*        : default hidden-layer geometry
//   - DEF_BIAS_BASE / bias_base() : first ROM word of the bias region, which
//     sits directly after the NUM_HIDDEN*NUM_INPUTS weight words.
// -----------------------------------------------------------------------------
package nn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_EMIT  = 3'd3,
      ST_FIN   = 3'd4
   } hseq_state_t;

   localparam int DATA_WIDTH     = 8;
   localparam int DEF_NUM_INPUTS = 784;
   localparam int DEF_NUM_HIDDEN = 32;
   localparam int DEF_ADDR_WIDTH = 15;
   localparam int DEF_IN_ADDR_W  = 10;

   // Bias words follow the weight matrix in the same ROM.
   function automatic int unsigned bias_base(input int unsigned num_inputs,
                                             input int unsigned num_hidden);
      return num_inputs * num_hidden;
   endfunction

   localparam int unsigned DEF_BIAS_BASE = DEF_NUM_INPUTS * DEF_NUM_HIDDEN;

endpackage

// File: rtl/hidden_layer_sequencer_addr_gen.sv
// -----------------------------------------------------------------------------
// hseq_addr_gen
//   Address generator for the hidden-layer sequencer. Walks the weight ROM
//   and input RAM with running adders (no multiplier):
//     weight_addr = base + i, input_addr = i, base advances by NUM_INPUTS
//   per neuron. Addresses hold their value whenever no step/load is requested.
//   Optional macro HIDDEN_SEQ_BIAS_EN: after input NUM_INPUTS-1 one extra
//   issue at the bias region (bias_base + neuron) with input_addr held.
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   init_i            load first neuron of a pass (base=0, i=0)
//   step_i            one issue slot in FETCH; advance unless on last issue
//   next_neuron_i     move to the next neuron (base+=NUM_INPUTS, i=0)
//   weight_addr_o     weight ROM address
//   input_addr_o      input RAM address
//   first_issue_o     current issue is input 0 of the neuron
//   last_issue_o      current issue is the final one of the neuron
//   bias_issue_o      current issue is the bias word (bias build only)
// -----------------------------------------------------------------------------
module hseq_addr_gen
   import nn_pkg::*;
#(
   parameter int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int NUM_HIDDEN = DEF_NUM_HIDDEN,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int IN_ADDR_W  = DEF_IN_ADDR_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  init_i,
   input  logic                  step_i,
   input  logic                  next_neuron_i,
   output logic [ADDR_WIDTH-1:0] weight_addr_o,
   output logic [IN_ADDR_W-1:0]  input_addr_o,
   output logic                  first_issue_o,
`ifdef HIDDEN_SEQ_BIAS_EN
   output logic                  last_issue_o,
   output logic                  bias_issue_o
`else
   output logic                  last_issue_o
`endif
);

`ifdef HIDDEN_SEQ_BIAS_EN
   localparam longint unsigned ROM_WORDS =
      longint'(NUM_HIDDEN) * longint'(NUM_INPUTS) + longint'(NUM_HIDDEN);
`else
   localparam longint unsigned ROM_WORDS =
      longint'(NUM_HIDDEN) * longint'(NUM_INPUTS);
`endif

   // Address ranges must never wrap.
   if (ROM_WORDS > (64'd1 << ADDR_WIDTH)) begin : g_rom_range_chk
      $error("hseq_addr_gen: weight ROM does not fit in ADDR_WIDTH bits");
   end
   if (longint'(NUM_INPUTS) > (64'd1 << IN_ADDR_W)) begin : g_ram_range_chk
      $error("hseq_addr_gen: input RAM does not fit in IN_ADDR_W bits");
   end

   localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(NUM_INPUTS);
   localparam logic [ADDR_WIDTH-1:0] ONE_W   = ADDR_WIDTH'(1);
   localparam logic [IN_ADDR_W-1:0]  ONE_I   = IN_ADDR_W'(1);
   localparam logic [IN_ADDR_W-1:0]  LAST_IN = IN_ADDR_W'(NUM_INPUTS - 1);

   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [IN_ADDR_W-1:0]  iaddr_q, iaddr_d;
   logic                  last_in;

   assign last_in = (iaddr_q == LAST_IN);

`ifdef HIDDEN_SEQ_BIAS_EN
   localparam logic [ADDR_WIDTH-1:0] BIAS_BASE =
      ADDR_WIDTH'(bias_base(NUM_INPUTS, NUM_HIDDEN));

   // bias_q tracks the bias word of the current neuron; bias_ph_q marks the
   // extra issue slot that follows the last input.
   logic [ADDR_WIDTH-1:0] bias_q, bias_d;
   logic                  bias_ph_q, bias_ph_d;

   always_comb begin
      base_d    = base_q;
      waddr_d   = waddr_q;
      iaddr_d   = iaddr_q;
      bias_d    = bias_q;
      bias_ph_d = bias_ph_q;
      if (init_i) begin
         base_d    = '0;
         waddr_d   = '0;
         iaddr_d   = '0;
         bias_d    = BIAS_BASE;
         bias_ph_d = 1'b0;
      end else if (next_neuron_i) begin
         base_d    = base_q + STRIDE;
         waddr_d   = base_q + STRIDE;
         iaddr_d   = '0;
         bias_d    = bias_q + ONE_W;
         bias_ph_d = 1'b0;
      end else if (step_i && !bias_ph_q) begin
         if (last_in) begin
            // input_addr is left on the last input for the bias slot
            waddr_d   = bias_q;
            bias_ph_d = 1'b1;
         end else begin
            waddr_d = waddr_q + ONE_W;
            iaddr_d = iaddr_q + ONE_I;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bias_q    <= '0;
         bias_ph_q <= 1'b0;
      end else begin
         bias_q    <= bias_d;
         bias_ph_q <= bias_ph_d;
      end
   end

   assign first_issue_o = (iaddr_q == '0) && !bias_ph_q;
   assign last_issue_o  = bias_ph_q;
   assign bias_issue_o  = bias_ph_q;
`else
   always_comb begin
      base_d  = base_q;
      waddr_d = waddr_q;
      iaddr_d = iaddr_q;
      if (init_i) begin
         base_d  = '0;
         waddr_d = '0;
         iaddr_d = '0;
      end else if (next_neuron_i) begin
         base_d  = base_q + STRIDE;
         waddr_d = base_q + STRIDE;
         iaddr_d = '0;
      end else if (step_i && !last_in) begin
         waddr_d = waddr_q + ONE_W;
         iaddr_d = iaddr_q + ONE_I;
      end
   end

   assign first_issue_o = (iaddr_q == '0);
   assign last_issue_o  = last_in;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_q  <= '0;
         waddr_q <= '0;
         iaddr_q <= '0;
      end else begin
         base_q  <= base_d;
         waddr_q <= waddr_d;
         iaddr_q <= iaddr_d;
      end
   end

   assign weight_addr_o = waddr_q;
   assign input_addr_o  = iaddr_q;

endmodule

// File: rtl/hidden_layer_sequencer.sv
// -----------------------------------------------------------------------------
// hidden_layer_sequencer
//   Runs one hidden-layer pass: for each neuron walks the weight ROM and input
//   RAM (both sync-read, 1-cycle latency), raises MAC strobes aligned to the
//   returned data, then offers the finished neuron downstream.
//   Optional macro HIDDEN_SEQ_BIAS_EN adds one bias fetch per neuron and the
//   bias_en output.
// Ports
//   clk, rst       clock, synchronous active-high reset (rst beats start)
//   start          1-cycle request for a pass; ignored while busy
//   busy           high from accepted start until the done cycle
//   done           1-cycle pulse after the last neuron is accepted
//   weight_addr    weight ROM address (neuron_idx*NUM_INPUTS + i)
//   input_addr     input RAM address (i)
//   mac_clr        with the first mac_en of a neuron: load, not accumulate
//   mac_en         ROM/RAM data valid this cycle
//   bias_en        bias word valid this cycle (bias build only)
//   neuron_valid   accumulator for neuron_idx complete
//   neuron_ready   downstream accepts the neuron
//   neuron_idx     current neuron
//   dbg_state      FSM state for observation
// Handshake: a neuron transfers on a cycle where neuron_valid && neuron_ready;
//   neuron_valid and neuron_idx hold until then, and addresses do not move.
// -----------------------------------------------------------------------------
module hidden_layer_sequencer
   import nn_pkg::*;
#(
   parameter int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int NUM_HIDDEN = DEF_NUM_HIDDEN,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int IN_ADDR_W  = DEF_IN_ADDR_W,
   parameter int IDX_W      = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] weight_addr,
   output logic [IN_ADDR_W-1:0]  input_addr,
   output logic                  mac_clr,
   output logic                  mac_en,
`ifdef HIDDEN_SEQ_BIAS_EN
   output logic                  bias_en,
`endif
   output logic                  neuron_valid,
   input  logic                  neuron_ready,
   output logic [IDX_W-1:0]      neuron_idx,
   output hseq_state_t           dbg_state
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HIDDEN - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   hseq_state_t      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mac_en_q, mac_clr_q;
   logic             init, step, next_neuron;
   logic             first_issue, last_issue, bias_issue;
   logic             issue;

   hseq_addr_gen #(
      .NUM_INPUTS (NUM_INPUTS),
      .NUM_HIDDEN (NUM_HIDDEN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .IN_ADDR_W  (IN_ADDR_W)
   ) u_addr_gen (
      .clk_i         (clk),
      .rst_i         (rst),
      .init_i        (init),
      .step_i        (step),
      .next_neuron_i (next_neuron),
      .weight_addr_o (weight_addr),
      .input_addr_o  (input_addr),
      .first_issue_o (first_issue),
`ifdef HIDDEN_SEQ_BIAS_EN
      .last_issue_o  (last_issue),
      .bias_issue_o  (bias_issue)
`else
      .last_issue_o  (last_issue)
`endif
   );

`ifndef HIDDEN_SEQ_BIAS_EN
   assign bias_issue = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      init        = 1'b0;
      step        = 1'b0;
      next_neuron = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               idx_d   = '0;
               init    = 1'b1;
            end
         end
         ST_FETCH: begin
            step = 1'b1;
            if (last_issue) begin
               state_d = ST_DRAIN;
            end
         end
         // One cycle for the read latency of the last issued address.
         ST_DRAIN: state_d = ST_EMIT;
         ST_EMIT: begin
            if (neuron_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_FIN;
               end else begin
                  state_d     = ST_FETCH;
                  idx_d       = idx_q + ONE_IDX;
                  next_neuron = 1'b1;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Strobes are the FETCH issue delayed by the memory read latency, so they
   // line up with weight_q/input_q coming back from the ROM/RAM.
   assign issue = (state_q == ST_FETCH);

   always_ff @(posedge clk) begin
      if (rst) begin
         mac_en_q  <= 1'b0;
         mac_clr_q <= 1'b0;
      end else begin
         mac_en_q  <= issue && !bias_issue;
         mac_clr_q <= issue && first_issue;
      end
   end

`ifdef HIDDEN_SEQ_BIAS_EN
   logic bias_en_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bias_en_q <= 1'b0;
      end else begin
         bias_en_q <= issue && bias_issue;
      end
   end

   assign bias_en = bias_en_q;
`endif

   assign mac_en       = mac_en_q;
   assign mac_clr      = mac_clr_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_FIN);
   assign neuron_valid = (state_q == ST_EMIT);
   assign neuron_idx   = idx_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
module tb_hidden_layer_sequencer;
  import nn_pkg::*;

  // ---------------- parameters ----------------
  localparam int NI = 4;
  localparam int NH = 3;
  localparam int AW = 5;
  localparam int IW = 2;
  localparam int XW = 2;
`ifdef HIDDEN_SEQ_BIAS_EN
  localparam int BX = 1;
`else
  localparam int BX = 0;
`endif
  localparam int EW = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // small instance
  logic start_s, busy_s, done_s, mac_clr_s, mac_en_s, valid_s, ready_s, bias_s;
  logic [AW-1:0] waddr_s;
  logic [IW-1:0] iaddr_s;
  logic [XW-1:0] idx_s;
  hseq_state_t   state_s;

  // default-parameter instance
  logic start_d, busy_d, done_d, mac_clr_d, mac_en_d, valid_d, ready_d, bias_d;
  logic [DEF_ADDR_WIDTH-1:0] waddr_d;
  logic [DEF_IN_ADDR_W-1:0]  iaddr_d;
  logic [4:0]                idx_d;
  hseq_state_t               state_d;

  hidden_layer_sequencer #(
    .NUM_INPUTS(NI), .NUM_HIDDEN(NH), .ADDR_WIDTH(AW), .IN_ADDR_W(IW), .IDX_W(XW)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .weight_addr(waddr_s), .input_addr(iaddr_s), .mac_clr(mac_clr_s), .mac_en(mac_en_s),
`ifdef HIDDEN_SEQ_BIAS_EN
    .bias_en(bias_s),
`endif
    .neuron_valid(valid_s), .neuron_ready(ready_s), .neuron_idx(idx_s), .dbg_state(state_s)
  );

  hidden_layer_sequencer dut_d (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d),
    .weight_addr(waddr_d), .input_addr(iaddr_d), .mac_clr(mac_clr_d), .mac_en(mac_en_d),
`ifdef HIDDEN_SEQ_BIAS_EN
    .bias_en(bias_d),
`endif
    .neuron_valid(valid_d), .neuron_ready(ready_d), .neuron_idx(idx_d), .dbg_state(state_d)
  );

`ifndef HIDDEN_SEQ_BIAS_EN
  initial begin
    bias_s = 1'b0;
    bias_d = 1'b0;
  end
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int prev_waddr, prev_iaddr, prev_idx;
  logic prev_valid, prev_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [1:0] kind, input logic clr,
                                         input int waddr, input int iaddr, input int idx);
    return {kind, clr, waddr[15:0], iaddr[15:0], idx[4:0]};
  endfunction

  // Expected strobe stream of one pass (kind 01 = mac, 10 = bias, 11 = neuron).
  task automatic push_pass();
    for (int n = 0; n < NH; n++) begin
      for (int i = 0; i < NI; i++)
        exp_q.push_back(pack(2'b01, (i == 0), n * NI + i, i, 0));
      if (BX == 1)
        exp_q.push_back(pack(2'b10, 1'b0, NH * NI + n, NI - 1, 0));
      exp_q.push_back(pack(2'b11, 1'b0, 0, 0, n));
    end
  endtask

  function automatic logic [63:0] outs_s();
    return {32'd0, busy_s, done_s, mac_clr_s, mac_en_s, bias_s, valid_s,
            13'(waddr_s), 8'(iaddr_s), 5'(idx_s)};
  endfunction

  // Called once per cycle at the negedge, after inputs for the cycle are set.
  task automatic monitor();
    logic [EW-1:0] e;
    if (mac_en_s || bias_s) begin
      if (exp_q.size() == 0) check("strobe_unexpected", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        // ROM/RAM model: data now is from the address issued last cycle
        check("strobe", 64'(pack({bias_s, mac_en_s}, mac_clr_s, prev_waddr, prev_iaddr, 0)), 64'(e));
      end
    end else begin
      check("clr_without_en", 64'(mac_clr_s), 64'(0));
    end
    if (valid_s && ready_s) begin
      if (exp_q.size() == 0) check("neuron_unexpected", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("neuron", 64'(pack(2'b11, 1'b0, 0, 0, int'(idx_s))), 64'(e));
      end
    end
    if (prev_valid && !prev_ready)
      check("backpressure_hold", {valid_s, 8'(idx_s), 16'(waddr_s), 16'(iaddr_s)},
            {1'b1, 8'(prev_idx), 16'(prev_waddr), 16'(prev_iaddr)});
    prev_waddr = int'(waddr_s);
    prev_iaddr = int'(iaddr_s);
    prev_idx   = int'(idx_s);
    prev_valid = valid_s;
    prev_ready = ready_s;
  endtask

  // ---------------- driver ----------------
  typedef struct {
    int stall_idx;
    int stall_len;
    bit extra_start;
    int exp_done;
  } scen_t;

  // Runs one pass on the small instance; entered and left at a negedge.
  task automatic run_pass(input int stall_idx, input int stall_len, input bit extra_start,
                          output int done_cyc, output int done_cnt);
    int cyc, stalled;
    bit extra_done;
    push_pass();
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    start_s = 1'b1;
    ready_s = 1'b1;
    cyc = 0; stalled = 0; extra_done = 0; done_cyc = -1; done_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      start_s = 1'b0;
      if (extra_start && !extra_done && state_s == ST_FETCH && idx_s == 2'd1) begin
        start_s = 1'b1;
        extra_done = 1;
      end
      if (valid_s && int'(idx_s) == stall_idx && stalled < stall_len) begin
        ready_s = 1'b0;
        stalled++;
      end else begin
        ready_s = 1'b1;
      end
      monitor();
      if (cyc == 1) check("busy_after_start", 64'(busy_s), 64'(1));
      if (done_s) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1)
        check("idle_after_done", {busy_s, 5'(state_s)}, {1'b0, 5'(ST_IDLE)});
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    start_s = 1'b0;
    ready_s = 1'b1;
  endtask

  // ---------------- test ----------------
  scen_t tbl[5];

  initial begin
    int dc, dn, cnt_mac, cnt_bias, last_w, cyc;
    bit saw_done;

    rst = 1'b1; start_s = 1'b0; ready_s = 1'b1; start_d = 1'b0; ready_d = 1'b1;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_waddr = 0; prev_iaddr = 0; prev_idx = 0;

    // 1: reset held 3 cycles, then idle without start
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_outputs", outs_s(), 64'(0));
      check("reset_state", 64'(state_s), 64'(ST_IDLE));
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_outputs", outs_s(), 64'(0));
    end

    // 2-4: table of passes (plain, backpressure at several neurons, stray start)
    tbl[0] = '{stall_idx: -1, stall_len: 0, extra_start: 1'b0, exp_done: 0};
    tbl[1] = '{stall_idx:  1, stall_len: 5, extra_start: 1'b0, exp_done: 0};
    tbl[2] = '{stall_idx:  0, stall_len: 2, extra_start: 1'b0, exp_done: 0};
    tbl[3] = '{stall_idx:  2, stall_len: 3, extra_start: 1'b0, exp_done: 0};
    tbl[4] = '{stall_idx: -1, stall_len: 0, extra_start: 1'b1, exp_done: 0};
    for (int t = 0; t < 5; t++)
      tbl[t].exp_done = NH * (NI + 2 + BX) + 1 + tbl[t].stall_len;

    for (int t = 0; t < 5; t++) begin
      run_pass(tbl[t].stall_idx, tbl[t].stall_len, tbl[t].extra_start, dc, dn);
      check($sformatf("done_cycle[%0d]", t), 64'(dc), 64'(tbl[t].exp_done));
      check($sformatf("done_count[%0d]", t), 64'(dn), 64'(1));
      check($sformatf("sb_empty[%0d]", t), 64'(exp_q.size()), 64'(0));
    end

    // 5: reset in the middle of neuron 1
    push_pass();
    prev_valid = 1'b0;
    start_s = 1'b1;
    saw_done = 0;
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      cyc++;
      monitor();
      if (waddr_s == 5'd6) break;
    end
    check("mid_rst_reached_addr6", 64'(waddr_s), 64'(6));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", outs_s(), 64'(0));
    check("mid_rst_state", 64'(state_s), 64'(ST_IDLE));
    exp_q.delete();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_s) saw_done = 1;
    end
    check("mid_rst_no_done", 64'(saw_done), 64'(0));
    run_pass(-1, 0, 1'b0, dc, dn);
    check("restart_done_cycle", 64'(dc), 64'(NH * (NI + 2 + BX) + 1));
    check("restart_sb_empty", 64'(exp_q.size()), 64'(0));

    // 6: full default-size pass
    start_d = 1'b1;
    cnt_mac = 0; cnt_bias = 0; last_w = -1; dc = -1;
    for (int k = 1; k < 30000; k++) begin
      @(negedge clk);
      start_d = 1'b0;
      if (mac_en_d) cnt_mac++;
      if (bias_d) cnt_bias++;
      if (done_d) begin
        dc = k;
        last_w = int'(waddr_d);
        break;
      end
    end
    check("def_done_cycle", 64'(dc), 64'(DEF_NUM_HIDDEN * (DEF_NUM_INPUTS + 2 + BX) + 1));
    check("def_mac_count", 64'(cnt_mac), 64'(DEF_NUM_HIDDEN * DEF_NUM_INPUTS));
    check("def_bias_count", 64'(cnt_bias), 64'(BX * DEF_NUM_HIDDEN));
    check("def_last_waddr", 64'(last_w),
          64'((BX == 1) ? (DEF_BIAS_BASE + DEF_NUM_HIDDEN - 1) : (DEF_NUM_HIDDEN * DEF_NUM_INPUTS - 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
